// File: rtl/addsub_pkg.sv
// Shared definitions for the arbitrated add/subtract unit: FSM encoding, op and requester codes.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;
    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/addsub_arbiter_rr_arb2.sv
// Two-request round-robin arbiter; the last winner loses the next tie.
module rr_arb2
    import addsub_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0_c,
    output logic gnt1_c
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt0_c       = en & req0 & (~req1 | (last_grant_q == ID_REQ1));
        gnt1_c       = en & req1 & (~req0 | (last_grant_q == ID_REQ0));
        last_grant_d = last_grant_q;
        if (gnt0_c) begin
            last_grant_d = ID_REQ0;
        end else if (gnt1_c) begin
            last_grant_d = ID_REQ1;
        end
    end

    // Reset to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ID_REQ1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mux_2_to_1.sv
// Single-bit 2-to-1 multiplexer cell: sel=0 passes d0, sel=1 passes d1.
module mux_2_to_1 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y_c
);

    assign y_c = sel ? d1 : d0;

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one WIDTH-bit adder/subtractor between two requesters; returns the
// registered result tagged with the owner's ID on a single response channel.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             busy
);

    localparam int unsigned SUM_W = WIDTH + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_q, op_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             rsp_id_q, rsp_id_d;

    logic             arb_en_c;
    logic             gnt0_c, gnt1_c;
    logic             sel_c;
    logic [WIDTH-1:0] mux_a_c, mux_b_c;
    logic             mux_op_c;
    logic [WIDTH-1:0] b_eff_c;
    logic [SUM_W-1:0] sum_c;

    assign arb_en_c = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en_c),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .gnt0_c (gnt0_c),
        .gnt1_c (gnt1_c)
    );

    assign sel_c = gnt1_c ? ID_REQ1 : ID_REQ0;

    // Per-bit operand steering toward the shared datapath.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_mux
        mux_2_to_1 u_mux_a (
            .d0  (req0_a[i]),
            .d1  (req1_a[i]),
            .sel (sel_c),
            .y_c (mux_a_c[i])
        );
        mux_2_to_1 u_mux_b (
            .d0  (req0_b[i]),
            .d1  (req1_b[i]),
            .sel (sel_c),
            .y_c (mux_b_c[i])
        );
    end

    mux_2_to_1 u_mux_op (
        .d0  (req0_op),
        .d1  (req1_op),
        .sel (sel_c),
        .y_c (mux_op_c)
    );

    // Subtract as A + ~B + 1; the carry-out then means "no borrow".
    always_comb begin
        b_eff_c = (op_q == OP_SUB) ? ~b_q : b_q;
        sum_c   = SUM_W'(a_q) + SUM_W'(b_eff_c) + SUM_W'(op_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        id_d     = id_q;
        result_d = result_q;
        cout_d   = cout_q;
        rsp_id_d = rsp_id_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0_c || gnt1_c) begin
                    a_d     = mux_a_c;
                    b_d     = mux_b_c;
                    op_d    = mux_op_c;
                    id_d    = sel_c;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = sum_c[WIDTH-1:0];
                cout_d   = sum_c[WIDTH];
                rsp_id_d = id_q;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            id_q     <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            rsp_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign req0_ready = gnt0_c;
    assign req1_ready = gnt1_c;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = result_q;
    assign rsp_cout   = cout_q;

endmodule
